// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port fixed-latency memory between
// the instruction-fetch port and the load/store data port. Round-robin grant,
// a single outstanding transaction, one-cycle response pulse to the owner.
module unified_mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1,
   parameter int CNT_W       = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req_valid,
   output logic                  if_req_ready,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic                  if_rsp_valid,
   output logic [DATA_W-1:0]     if_rdata,
   input  logic                  d_req_valid,
   output logic                  d_req_ready,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic                  d_we,
   input  logic [DATA_W-1:0]     d_wdata,
   input  logic [DATA_W/8-1:0]   d_wstrb,
   output logic                  d_rsp_valid,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wstrb,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  busy
);

   localparam int STRB_W = DATA_W / 8;
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t              state_reg;
   logic                owner_reg;       // 1 = data port owns the transaction
   logic                last_grant_reg;  // 1 = data port was granted last
   logic [CNT_W-1:0]    count_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic                we_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic [STRB_W-1:0]   wstrb_reg;
   logic [DATA_W-1:0]   if_rdata_reg;
   logic [DATA_W-1:0]   d_rdata_reg;

   logic                grant_if;
   logic                grant_d;

   // Round-robin: fetch wins unless data is also waiting and fetch went last.
   always_comb begin
      grant_if = if_req_valid && (!d_req_valid || last_grant_reg);
      grant_d  = d_req_valid && !grant_if;
   end

   assign if_req_ready = (state_reg == IDLE) && grant_if;
   assign d_req_ready  = (state_reg == IDLE) && grant_d;
   assign mem_req      = (state_reg == ISSUE);
   assign mem_we       = (state_reg == ISSUE) && we_reg;
   assign mem_addr     = addr_reg;
   assign mem_wdata    = wdata_reg;
   assign mem_wstrb    = wstrb_reg;
   assign if_rsp_valid = (state_reg == RESP) && !owner_reg;
   assign d_rsp_valid  = (state_reg == RESP) && owner_reg;
   assign if_rdata     = if_rdata_reg;
   assign d_rdata      = d_rdata_reg;
   assign busy         = (state_reg != IDLE);

   // Transaction sequencer: accept, strobe memory, wait out latency, respond.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         owner_reg      <= 1'b0;
         last_grant_reg <= 1'b1;
         count_reg      <= '0;
         addr_reg       <= '0;
         we_reg         <= 1'b0;
         wdata_reg      <= '0;
         wstrb_reg      <= '0;
         if_rdata_reg   <= '0;
         d_rdata_reg    <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (grant_if || grant_d) begin
                  owner_reg      <= grant_d;
                  last_grant_reg <= grant_d;
                  addr_reg       <= grant_d ? d_addr : if_addr;
                  // The fetch port is read-only: no write, no byte enables.
                  we_reg         <= grant_d && d_we;
                  wdata_reg      <= grant_d ? d_wdata : '0;
                  wstrb_reg      <= grant_d ? d_wstrb : '0;
                  state_reg      <= ISSUE;
               end
            end
            ISSUE: begin
               count_reg <= LAT_LOAD;
               state_reg <= WAIT;
            end
            WAIT: begin
               if (count_reg == '0) begin
                  if (owner_reg)
                     d_rdata_reg <= we_reg ? '0 : mem_rdata;
                  else
                     if_rdata_reg <= mem_rdata;
                  state_reg <= RESP;
               end else begin
                  count_reg <= count_reg - 1'b1;
               end
            end
            RESP: begin
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Testbench for unified_mem_arbiter: four instances with MEM_LATENCY 1..4,
// each with its own memory model; only the selected instance sees requests.
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   int          sel;
   logic        if_valid, d_valid, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [3:0]  d_wstrb;

   logic        if_ready [4];
   logic        if_rsp   [4];
   logic [31:0] if_rd    [4];
   logic        d_ready  [4];
   logic        d_rsp    [4];
   logic [31:0] d_rd     [4];
   logic        m_req    [4];
   logic        m_we     [4];
   logic [31:0] m_addr   [4];
   logic [31:0] m_wdata  [4];
   logic [3:0]  m_wstrb  [4];
   logic [31:0] m_rdata  [4];
   logic        busy_o   [4];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      logic [31:0] mem  [0:255];
      logic [31:0] pipe [0:gi];

      unified_mem_arbiter #(.MEM_LATENCY(gi + 1)) dut (
         .clk          (clk),
         .reset        (reset),
         .if_req_valid (if_valid && (sel == gi)),
         .if_req_ready (if_ready[gi]),
         .if_addr      (if_addr),
         .if_rsp_valid (if_rsp[gi]),
         .if_rdata     (if_rd[gi]),
         .d_req_valid  (d_valid && (sel == gi)),
         .d_req_ready  (d_ready[gi]),
         .d_addr       (d_addr),
         .d_we         (d_we),
         .d_wdata      (d_wdata),
         .d_wstrb      (d_wstrb),
         .d_rsp_valid  (d_rsp[gi]),
         .d_rdata      (d_rd[gi]),
         .mem_req      (m_req[gi]),
         .mem_we       (m_we[gi]),
         .mem_addr     (m_addr[gi]),
         .mem_wdata    (m_wdata[gi]),
         .mem_wstrb    (m_wstrb[gi]),
         .mem_rdata    (m_rdata[gi]),
         .busy         (busy_o[gi])
      );

      assign m_rdata[gi] = pipe[gi];

      // Memory model: preload on reset, byte-enabled writes, read data
      // delayed through a gi+1 deep pipeline after the strobe.
      always @(posedge clk) begin
         if (reset) begin
            for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
            mem[1]   <= 32'h0051_0113;
            mem[128] <= 32'h1111_1111;
            pipe[0]  <= 32'h0;
         end else if (m_req[gi]) begin
            if (m_we[gi]) begin
               for (int b = 0; b < 4; b++)
                  if (m_wstrb[gi][b]) mem[m_addr[gi][9:2]][8*b +: 8] <= m_wdata[gi][8*b +: 8];
            end
            pipe[0] <= mem[m_addr[gi][9:2]];
         end
         for (int k = 1; k <= gi; k++) pipe[k] <= pipe[k-1];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction with cycle-exact checks against MEM_LATENCY = s+1.
   task automatic do_txn(input int s, input bit data, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [31:0] exp_rdata, input string name);
      int lat;
      lat = s + 1;
      sel = s;
      if (data) begin
         d_valid = 1'b1; d_addr = addr; d_we = we; d_wdata = wdata; d_wstrb = strb;
      end else begin
         if_valid = 1'b1; if_addr = addr;
      end
      #1;
      check({name, " ready"}, data ? d_ready[s] : if_ready[s], 32'd1);
      check({name, " other_ready"}, data ? if_ready[s] : d_ready[s], 32'd0);
      tick();
      if_valid = 1'b0; d_valid = 1'b0;
      check({name, " mem_req"}, m_req[s], 32'd1);
      check({name, " mem_addr"}, m_addr[s], addr);
      check({name, " mem_we"}, m_we[s], data && we);
      check({name, " mem_wstrb"}, m_wstrb[s], data ? strb : 4'h0);
      if (data && we) check({name, " mem_wdata"}, m_wdata[s], wdata);
      for (int c = 0; c < lat; c++) begin
         tick();
         check({name, " wait_quiet"}, {m_req[s], if_rsp[s], d_rsp[s], busy_o[s]}, 32'd1);
      end
      tick();
      check({name, " rsp_valid"}, data ? d_rsp[s] : if_rsp[s], 32'd1);
      check({name, " other_rsp"}, data ? if_rsp[s] : d_rsp[s], 32'd0);
      check({name, " rdata"}, data ? d_rd[s] : if_rd[s], exp_rdata);
      $display("txn %s lat=%0d addr=0x%08h rdata=0x%08h", name, lat, addr,
               data ? d_rd[s] : if_rd[s]);
      tick();
      check({name, " rsp_drop"}, {if_rsp[s], d_rsp[s], busy_o[s]}, 32'd0);
      check({name, " rdata_hold"}, data ? d_rd[s] : if_rd[s], exp_rdata);
   endtask

   initial begin
      int gcyc[$];
      bit gport[$];
      int acc[$];
      int rsp[$];
      int pulses;

      reset = 1'b1; sel = 0; if_valid = 0; d_valid = 0; d_we = 0;
      if_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
      tick(); tick();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("reset ctl%0d", i),
               {busy_o[i], m_req[i], m_we[i], if_ready[i], d_ready[i], if_rsp[i], d_rsp[i]}, 32'd0);
         check($sformatf("reset data%0d", i), if_rd[i] | d_rd[i] | m_addr[i] | m_wdata[i], 32'd0);
         check($sformatf("reset wstrb%0d", i), m_wstrb[i], 32'd0);
      end
      reset = 1'b0;
      tick();

      // Single fetch, latency 1.
      do_txn(0, 1'b0, 1'b0, 32'h4, 32'h0, 4'h0, 32'h0051_0113, "fetch_l1");

      // Store then load, latency 3; byte store with readback.
      do_txn(2, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0, "store_l3");
      do_txn(2, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF, "load_l3");
      do_txn(2, 1'b1, 1'b1, 32'h200, 32'h0000_AB00, 4'h2, 32'h0, "bytestore_l3");
      do_txn(2, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h1111_AB11, "byteload_l3");

      // Both requesters held after reset, latency 1: expect F, D, F, D.
      sel = 0; reset = 1'b1;
      if_valid = 1'b1; if_addr = 32'h4;
      d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wstrb = 4'h0;
      tick(); reset = 1'b0;
      for (int c = 0; c < 40 && gcyc.size() < 4; c++) begin
         if (if_ready[0] && d_ready[0]) check("tie both_ready", 32'd1, 32'd0);
         if (if_ready[0] || d_ready[0]) begin
            gcyc.push_back(c);
            gport.push_back(d_ready[0]);
            $display("txn tie grant=%s cycle=%0d", d_ready[0] ? "data" : "fetch", c);
         end
         tick();
      end
      check("tie grants", gcyc.size(), 32'd4);
      if (gcyc.size() == 4) begin
         check("tie order", {gport[0], gport[1], gport[2], gport[3]}, 32'b0101);
         check("tie gap", gcyc[3] - gcyc[0], 32'd12);
      end
      if_valid = 1'b0; d_valid = 1'b0;
      for (int c = 0; c < 6; c++) tick();
      check("tie idle", busy_o[0], 32'd0);

      // Back-to-back fetches, latency 2: period 5, response offset 4.
      sel = 1; if_valid = 1'b1; if_addr = 32'h4;
      #1;
      for (int c = 0; c < 40 && acc.size() < 4; c++) begin
         if (if_ready[1]) acc.push_back(c);
         if (if_rsp[1]) begin
            rsp.push_back(c);
            $display("txn b2b rsp cycle=%0d rdata=0x%08h", c, if_rd[1]);
         end
         tick();
      end
      if_valid = 1'b0;
      check("b2b accepts", acc.size(), 32'd4);
      check("b2b rsps", rsp.size() >= 3, 32'd1);
      if (acc.size() == 4 && rsp.size() >= 3) begin
         check("b2b period1", acc[1] - acc[0], 32'd5);
         check("b2b period2", acc[2] - acc[1], 32'd5);
         check("b2b offset0", rsp[0] - acc[0], 32'd4);
         check("b2b offset2", rsp[2] - acc[2], 32'd4);
         check("b2b rdata", if_rd[1], 32'h0051_0113);
      end
      for (int c = 0; c < 8; c++) tick();

      // Reset during WAIT, latency 4: transaction abandoned.
      sel = 3; if_valid = 1'b1; if_addr = 32'h4;
      #1;
      check("rst_wait ready", if_ready[3], 32'd1);
      tick(); if_valid = 1'b0;
      tick(); tick();
      check("rst_wait busy_before", busy_o[3], 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_wait ctl", {busy_o[3], m_req[3], m_we[3], if_rsp[3], d_rsp[3], if_ready[3]}, 32'd0);
      check("rst_wait data", if_rd[3] | m_addr[3] | m_wdata[3], 32'd0);
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         if (if_rsp[3] || d_rsp[3]) pulses++;
         tick();
      end
      check("rst_wait no_rsp", pulses, 32'd0);
      do_txn(3, 1'b0, 1'b0, 32'h4, 32'h0, 4'h0, 32'h0051_0113, "fetch_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the CPU instruction-fetch path (PC → fetch, read-only) and the load/store data path.
- Sits between the CPU core and the memory; replaces the private instruction-memory connection when the core goes multi-cycle.
- Round-robin arbitration, one outstanding transaction, fixed-latency memory, one-cycle response pulse per requester.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; wstrb width = DATA_W/8
MEM_LATENCY, 1, cycles from mem_req to valid mem_rdata; legal 1..15
CNT_W, 4, latency counter width; must satisfy 2^CNT_W > MEM_LATENCY

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
if_req_valid  in  1  fetch request pending
if_req_ready  out  1  fetch request accepted this cycle
if_addr  in  ADDR_W  fetch address (PC)
if_rsp_valid  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  DATA_W  fetched instruction
d_req_valid  in  1  data request pending
d_req_ready  out  1  data request accepted this cycle
d_addr  in  ADDR_W  data address
d_we  in  1  1 = store, 0 = load
d_wdata  in  DATA_W  store data
d_wstrb  in  DATA_W/8  byte enables for stores
d_rsp_valid  out  1  one-cycle pulse; load data or store ack
d_rdata  out  DATA_W  load data; 0 for store acks
mem_req  out  1  one-cycle memory strobe
mem_we  out  1  write enable, qualified by mem_req
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data
busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, grant rule:
  - Only one requester valid: that requester is granted.
  - Both valid: the port not in last_grant is granted.
  - The granted port's req_ready is driven high combinationally in IDLE. The other ready stays low.
  - On the accepting edge, capture owner, addr, we, wdata and wstrb (the fetch port is forced to we=0, wstrb=0), update last_grant, and go to ISSUE.
- No req_valid in IDLE: stay in IDLE; all ready outputs low.
- ISSUE: mem_req=1 for exactly one cycle, with mem_we/mem_addr/mem_wdata/mem_wstrb driven from the captured registers. Load counter with MEM_LATENCY-1 and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0:
  - Register mem_rdata into the owner's rdata register (store: load 0).
  - Go to RESP.
- RESP: the owner's rsp_valid is high for exactly one cycle, and its rdata holds until the next response. Go to IDLE.
- Timing:
  - Acceptance in cycle N gives mem_req in N+1, mem_rdata sampled at the end of N+1+MEM_LATENCY, and rsp_valid in N+2+MEM_LATENCY.
  - Next acceptance is possible at the earliest in N+3+MEM_LATENCY.
- Memory-side outputs:
  - mem_addr/wdata/wstrb/we hold their captured values outside ISSUE.
  - mem_req and mem_we are 0 outside ISSUE.
- Requester handshake rules:
  - A requester holds valid and its fields stable until ready.
  - A requester must accept rsp_valid unconditionally; there is no back-pressure.
  - req_valid toggling in non-IDLE states is ignored.
- Reset values:
  - State IDLE; last_grant = data port, so the first tie goes to fetch.
  - All ready/rsp_valid/mem_req/mem_we = 0; if_rdata/d_rdata = 0; mem_addr/wdata/wstrb = 0; counter = 0; busy = 0.
- Reset mid-transaction: the transaction is abandoned. No rsp_valid is produced, and mem_req drops in the cycle after the reset edge.
- A request asserted in the same cycle that RESP completes waits one cycle, because acceptance occurs only in IDLE.
- Addresses pass through unmodified; there are no alignment checks in this block.

Test Plan:
- Single fetch, MEM_LATENCY=1. Stimulus: if_addr=0x0000_0004, memory returns 0x0051_0113. Response: if_req_ready in cycle 0, mem_req in cycle 1 with mem_addr=0x4, if_rsp_valid in cycle 3 with if_rdata=0x0051_0113; d_rsp_valid stays 0.
- Store then load, MEM_LATENCY=3. Stimulus: d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_wstrb=0xF. Response: mem_we=1 for one cycle, d_rsp_valid in cycle 5 with d_rdata=0. A following load of 0x100 returns 0xDEAD_BEEF.
- Simultaneous requests held continuously after reset. Response: grant order fetch, data, fetch, data. No port is granted twice in a row while the other is waiting.
- Byte store. Stimulus: d_wstrb=0x2, d_wdata=0x0000_AB00, addr 0x200 preloaded 0x1111_1111. Response: mem_wstrb=0x2; readback gives 0x1111_AB11.
- Reset asserted during WAIT, MEM_LATENCY=4. Response: busy=0, all outputs at reset values on the next cycle, no rsp_valid pulse. The next fetch completes normally.
- Back-to-back fetches, MEM_LATENCY=2. Stimulus: if_req_valid held high. Response: if_req_ready pulses every 5 cycles; if_rsp_valid pulses every 5 cycles, offset 4 from each acceptance.
